// File: rtl/mcp_rx_ack.sv
// -----------------------------------------------------------------------------
// mcp_rx_ack
//   Receive (clk1) side of a toggle-request multi-cycle-path CDC transfer.
//   The sender parks a word in data_in and flips req_t. This block
//   synchronises req_t and detects the flip. It captures data_in, which is
//   guaranteed stable at that point. It then offers the word on a
//   valid/ready stream and toggles ack_t back so the sender may reuse its
//   holding register.
//
// Ports
//   clk1      in   receive-domain clock, rising edge
//   rst       in   asynchronous active-low reset
//   en        in   clock enable for the FSM (edges still latch while low)
//   req_t     in   request toggle from the sender domain (asynchronous)
//   data_in   in   sender holding register, quasi-static
//   ack_t     out  acknowledge toggle back to the sender (registered)
//   m_tvalid  out  stream valid
//   m_tready  in   stream ready
//   m_tdata   out  captured word
//   xfer_cnt  out  count of completed stream handshakes, wraps
//   overrun   out  sticky protocol-violation flag
//   ovr_clr   in   single-cycle clear for overrun (set wins)
// -----------------------------------------------------------------------------
module mcp_rx_ack #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SYNC_STAGES = 2,   // must be >= 2
  parameter int unsigned ACK_EARLY   = 0,   // 0: ack on handshake, 1: ack on capture
  parameter int unsigned CNT_W       = 8
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              en,
  input  logic              req_t,
  input  logic [DATA_W-1:0] data_in,
  output logic              ack_t,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic              overrun,
  input  logic              ovr_clr
);

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_t;

  state_t state_q, state_d;

  // req_t synchroniser. Only sync_q[0] ever sees the asynchronous input.
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_dly_q, sync_dly_d;
  logic                   sync_out;
  logic                   req_edge;

  logic                   pending_q, pending_d;
  logic                   ack_q, ack_d;
  logic                   tvalid_q, tvalid_d;
  logic [DATA_W-1:0]      tdata_q, tdata_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   overrun_q, overrun_d;

  logic                   accept;
  logic                   handshake;
  logic                   ovr_set;

  // Synchroniser and edge flop run every cycle regardless of en, so a flip
  // that arrives while frozen is still seen exactly once.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], req_t};
    sync_dly_d = sync_out;
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign req_edge = sync_out ^ sync_dly_q;

  assign accept    = (state_q == IDLE)  && en && (req_edge || pending_q);
  assign handshake = (state_q == VALID) && en && m_tready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = VALID;
      VALID:   if (handshake) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    pending_d = pending_q;
    ack_d     = ack_q;
    tvalid_d  = tvalid_q;
    tdata_d   = tdata_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;

    // A flip that is not consumed by an accept this cycle is remembered.
    // Only one can be remembered: a flip on top of a pending one is lost
    // (and flagged below). An accept always drains pending.
    if (accept) begin
      tvalid_d  = 1'b1;
      tdata_d   = data_in;
      pending_d = 1'b0;
      if (ACK_EARLY != 0) ack_d = ~ack_q;
    end else if (req_edge) begin
      pending_d = 1'b1;
    end

    // accept and handshake are mutually exclusive (different states).
    if (handshake) begin
      tvalid_d = 1'b0;
      cnt_d    = cnt_q + CNT_W'(1);
      if (ACK_EARLY == 0) ack_d = ~ack_q;
    end

    // With late ack the sender must not flip again before the word leaves,
    // so a flip while VALID is a violation even though it is still queued.
    ovr_set = req_edge && (pending_q || ((ACK_EARLY == 0) && (state_q == VALID)));
    if (ovr_set) begin
      overrun_d = 1'b1;
    end else if (ovr_clr) begin
      overrun_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      sync_q     <= '0;
      sync_dly_q <= 1'b0;
      pending_q  <= 1'b0;
      ack_q      <= 1'b0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      cnt_q      <= '0;
      overrun_q  <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      sync_dly_q <= sync_dly_d;
      pending_q  <= pending_d;
      ack_q      <= ack_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      cnt_q      <= cnt_d;
      overrun_q  <= overrun_d;
    end
  end

  assign ack_t    = ack_q;
  assign m_tvalid = tvalid_q;
  assign m_tdata  = tdata_q;
  assign xfer_cnt = cnt_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_mcp_rx_ack.sv
// -----------------------------------------------------------------------------
// tb_mcp_rx_ack
//   Two receivers share clk1/rst:
//     u_a : ACK_EARLY=0, CNT_W=2  (single word, backpressure, overrun, wrap, en)
//     u_b : ACK_EARLY=1, CNT_W=8  (streamed words using pending)
//   Expected words are queued when the sender issues them; per-instance
//   monitors pop and compare on every stream handshake.
// -----------------------------------------------------------------------------
module tb_mcp_rx_ack;

  logic clk1 = 1'b0;
  logic rst;

  // instance A
  logic        en_a, req_a, tready_a, ovr_clr_a;
  logic [31:0] data_in_a;
  logic        ack_a, tvalid_a, ovr_a;
  logic [31:0] tdata_a;
  logic [1:0]  cnt_a;

  // instance B
  logic        en_b, req_b, tready_b, ovr_clr_b;
  logic [31:0] data_in_b;
  logic        ack_b, tvalid_b, ovr_b;
  logic [31:0] tdata_b;
  logic [7:0]  cnt_b;

  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk1 = ~clk1;

  mcp_rx_ack #(.DATA_W(32), .SYNC_STAGES(2), .ACK_EARLY(0), .CNT_W(2)) u_a (
    .clk1(clk1), .rst(rst), .en(en_a), .req_t(req_a), .data_in(data_in_a),
    .ack_t(ack_a), .m_tvalid(tvalid_a), .m_tready(tready_a), .m_tdata(tdata_a),
    .xfer_cnt(cnt_a), .overrun(ovr_a), .ovr_clr(ovr_clr_a)
  );

  mcp_rx_ack #(.DATA_W(32), .SYNC_STAGES(2), .ACK_EARLY(1), .CNT_W(8)) u_b (
    .clk1(clk1), .rst(rst), .en(en_b), .req_t(req_b), .data_in(data_in_b),
    .ack_t(ack_b), .m_tvalid(tvalid_b), .m_tready(tready_b), .m_tdata(tdata_b),
    .xfer_cnt(cnt_b), .overrun(ovr_b), .ovr_clr(ovr_clr_b)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk1);
      #1;
    end
  endtask

  task automatic send_a(input logic [31:0] d);
    data_in_a = d;
    exp_a.push_back(d);
    req_a = ~req_a;
    $display("A send %h", d);
  endtask

  // Scoreboard monitors: a handshake happens at the next rising edge.
  always @(negedge clk1) begin
    if (rst && en_a && tvalid_a && tready_a) begin
      if (exp_a.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL a_word: got %h expected none", tdata_a);
      end else begin
        $display("A recv %h", tdata_a);
        chk("a_word", tdata_a, exp_a.pop_front());
      end
    end
  end

  always @(negedge clk1) begin
    if (rst && en_b && tvalid_b && tready_b) begin
      if (exp_b.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL b_word: got %h expected none", tdata_b);
      end else begin
        $display("B recv %h", tdata_b);
        chk("b_word", tdata_b, exp_b.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    en_a = 1'b1; req_a = 1'b0; tready_a = 1'b0; ovr_clr_a = 1'b0; data_in_a = '0;
    en_b = 1'b1; req_b = 1'b0; tready_b = 1'b0; ovr_clr_b = 1'b0; data_in_b = '0;
    #1 rst = 1'b0;
    #1;
    chk("rst_a_valid", tvalid_a, 0);
    chk("rst_a_ack",   ack_a,    0);
    chk("rst_a_cnt",   cnt_a,    0);
    chk("rst_a_ovr",   ovr_a,    0);
    chk("rst_b_valid", tvalid_b, 0);
    step(2);
    rst = 1'b1;
    step(2);

    // ---- single word, late ack, ready high ----
    tready_a = 1'b1;
    send_a(32'hA5A5_0001);
    step(1); chk("single_e1_valid", tvalid_a, 0);
    step(1); chk("single_e2_valid", tvalid_a, 0);
    step(1);
    chk("single_e3_valid", tvalid_a, 1);
    chk("single_e3_data",  tdata_a,  32'hA5A5_0001);
    chk("single_e3_ack",   ack_a,    0);
    step(1);
    chk("single_e4_ack",   ack_a,    1);
    chk("single_e4_valid", tvalid_a, 0);
    chk("single_e4_cnt",   cnt_a,    1);

    // ---- backpressure ----
    tready_a = 1'b0;
    send_a(32'hA5A5_0002);
    step(3);
    chk("bp_valid", tvalid_a, 1);
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("bp_hold_valid", tvalid_a, 1);
      chk("bp_hold_data",  tdata_a,  32'hA5A5_0002);
      chk("bp_hold_ack",   ack_a,    1);
    end
    tready_a = 1'b1;
    step(1);
    tready_a = 1'b0;
    chk("bp_hs_valid", tvalid_a, 0);
    chk("bp_hs_ack",   ack_a,    0);
    chk("bp_hs_cnt",   cnt_a,    2);

    // ---- overrun: second flip while VALID ----
    send_a(32'hA5A5_0003);
    step(3);
    chk("ovr_valid", tvalid_a, 1);
    send_a(32'hDEAD_0004);
    step(3);
    chk("ovr_set",  ovr_a,   1);
    chk("ovr_data", tdata_a, 32'hA5A5_0003);
    step(2);
    chk("ovr_sticky", ovr_a, 1);
    tready_a = 1'b1;
    step(1);
    chk("ovr_hs_valid", tvalid_a, 0);
    chk("ovr_hs_ack",   ack_a,    1);
    chk("ovr_hs_cnt",   cnt_a,    3);
    step(1);
    chk("ovr_pend_valid", tvalid_a, 1);
    chk("ovr_pend_data",  tdata_a,  32'hDEAD_0004);
    step(1);
    tready_a = 1'b0;
    chk("ovr_pend_cnt",   cnt_a, 0);
    chk("ovr_pend_ack",   ack_a, 0);
    chk("ovr_still_set",  ovr_a, 1);
    ovr_clr_a = 1'b1;
    step(1);
    ovr_clr_a = 1'b0;
    chk("ovr_cleared", ovr_a, 0);

    // ---- fifth word: counter wrap ----
    tready_a = 1'b1;
    send_a(32'h0000_0055);
    step(4);
    chk("wrap_cnt",   cnt_a,    1);
    chk("wrap_ack",   ack_a,    1);
    chk("wrap_valid", tvalid_a, 0);

    // ---- en=0 freezes accept and handshake ----
    tready_a = 1'b0;
    en_a = 1'b0;
    send_a(32'h0000_0066);
    step(6);
    chk("en0_no_valid", tvalid_a, 0);
    en_a = 1'b1;
    step(1);
    chk("en1_valid", tvalid_a, 1);
    chk("en1_data",  tdata_a,  32'h0000_0066);
    en_a = 1'b0;
    tready_a = 1'b1;
    step(3);
    chk("en0_ready_ignored_valid", tvalid_a, 1);
    chk("en0_ready_ignored_cnt",   cnt_a,    1);
    chk("en0_ready_ignored_ack",   ack_a,    1);
    en_a = 1'b1;
    step(1);
    tready_a = 1'b0;
    chk("en1_hs_valid", tvalid_a, 0);
    chk("en1_hs_cnt",   cnt_a,    2);
    chk("en1_hs_ack",   ack_a,    0);

    // ---- reset mid-VALID, with overrun set ----
    send_a(32'h0000_0077);
    step(3);
    chk("rstv_valid", tvalid_a, 1);
    send_a(32'h0000_0088);
    step(3);
    chk("rstv_ovr_pre", ovr_a, 1);
    #2;
    rst   = 1'b0;
    req_a = 1'b0;
    #1;
    chk("rstv_valid0", tvalid_a, 0);
    chk("rstv_ack0",   ack_a,    0);
    chk("rstv_cnt0",   cnt_a,    0);
    chk("rstv_ovr0",   ovr_a,    0);
    chk("rstv_data0",  tdata_a,  0);
    exp_a.delete();
    step(2);
    rst = 1'b1;
    step(2);

    // ---- early-ack stream on instance B ----
    fork
      begin : sender_b
        logic prev;
        logic nack;
        int   n;
        for (int w = 0; w < 4; w++) begin
          data_in_b = 32'h10 + w;
          exp_b.push_back(32'h10 + w);
          $display("B send %h", data_in_b);
          prev = ack_b;
          req_b = ~req_b;
          n = 0;
          while (ack_b == prev && n < 40) begin
            step(1);
            n++;
          end
          nack = ~prev;
          chk("b_ack_toggle", ack_b, nack);
        end
      end
      begin : ready_b
        int n;
        for (int w = 0; w < 4; w++) begin
          n = 0;
          while (!tvalid_b && n < 60) begin
            step(1);
            n++;
          end
          chk("b_valid_seen", tvalid_b, 1);
          step(5);
          tready_b = 1'b1;
          step(1);
          tready_b = 1'b0;
        end
      end
    join
    step(3);
    chk("b_cnt",     cnt_b, 4);
    chk("b_ovr",     ovr_b, 0);
    chk("b_ack_end", ack_b, 0);
    chk("b_q_empty", exp_b.size(), 0);
    chk("a_q_empty", exp_a.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
